// File: rtl/spike_gather_pkg.sv
// Shared constants and FSM encoding for the timestep sequencer / spike collector.
package spike_gather_pkg;

   localparam int unsigned N_NEURON = 18;
   localparam int unsigned IDX_W    = 5;
   localparam int unsigned CUR_W    = 25;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned FP_ONE   = 65536;
   localparam int unsigned INH_W    = 3 * FP_ONE;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StRun,
      StWait,
      StNext,
      StCommit
   } state_t;

endpackage

// File: rtl/spike_gather_inh_calc.sv
// Lateral inhibition: count spiking neighbours (excluding self), scale by INH_W, saturate.
module spike_gather_inh_calc
   import spike_gather_pkg::*;
(
   input  logic [N_NEURON-1:0] spk,
   input  logic [IDX_W-1:0]    idx,
   output logic [CUR_W-1:0]    current
);

   localparam logic [47:0] SAT = (48'd1 << (CUR_W - 1)) - 48'd1;

   logic [IDX_W-1:0] pop;
   logic [IDX_W-1:0] others;
   logic [47:0]      prod;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_NEURON; i++) begin
         pop = pop + IDX_W'(spk[i]);
      end
      others = pop;
      if ((idx < IDX_W'(N_NEURON)) && spk[idx]) begin
         others = pop - IDX_W'(1);
      end
      prod    = 48'(others) * 48'(INH_W);
      current = (prod > SAT) ? CUR_W'(SAT) : CUR_W'(prod);
   end

endmodule

// File: rtl/spike_gather.sv
// Walks neurons 0..N_NEURON-1 per timestep, drives the update engine and collects spikes,
// saturating per-neuron counters and a running winner.
module spike_gather
   import spike_gather_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_step,
   input  logic                i_clear,
   output logic                o_busy,
   output logic                o_exc_req,
   output logic [IDX_W-1:0]    o_exc_idx,
   input  logic                i_exc_valid,
   input  logic [CUR_W-1:0]    i_exc_current,
   output logic                o_run,
   output logic [CUR_W-1:0]    o_exc_current,
   output logic [CUR_W-1:0]    o_inh_current,
   input  logic                i_valid,
   input  logic                i_spike,
   input  logic [IDX_W-1:0]    i_neuron_idx,
   output logic [N_NEURON-1:0] o_spike_vec,
   output logic                o_step_done,
   output logic [IDX_W-1:0]    o_winner,
   output logic [CNT_W-1:0]    o_winner_cnt,
   input  logic [IDX_W-1:0]    i_rd_idx,
   output logic [CNT_W-1:0]    o_rd_cnt,
   output logic                o_err
);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    n_q;
   logic [N_NEURON-1:0] prev_spk_q;
   logic [N_NEURON-1:0] cur_spk_q;
   logic [CNT_W-1:0]    cnt_q [N_NEURON];

   logic [CUR_W-1:0]    inh_cur;
   logic [CNT_W-1:0]    cnt_new;
   logic                last_n;
   logic                do_clear;
   logic                do_step;
   logic                take_exc;
   logic                take_res;

   spike_gather_inh_calc u_inh_calc (
      .spk     (prev_spk_q),
      .idx     (n_q),
      .current (inh_cur)
   );

   assign last_n  = (n_q == IDX_W'(N_NEURON - 1));
   assign cnt_new = (!i_spike || (cnt_q[n_q] == '1)) ? cnt_q[n_q] : cnt_q[n_q] + CNT_W'(1);

   assign o_busy      = (state_q != StIdle);
   assign o_exc_req   = (state_q == StReq);
   assign o_run       = (state_q == StRun);
   assign o_step_done = (state_q == StCommit);
   assign o_exc_idx   = n_q;

   always_comb begin
      state_d  = state_q;
      do_clear = 1'b0;
      do_step  = 1'b0;
      take_exc = 1'b0;
      take_res = 1'b0;
      unique case (state_q)
         StIdle: begin
            // clear has priority; a simultaneous step is dropped
            if (i_clear) begin
               do_clear = 1'b1;
            end else if (i_step) begin
               do_step = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            if (i_exc_valid) begin
               take_exc = 1'b1;
               state_d  = StRun;
            end
         end
         StRun:    state_d = StWait;
         StWait: begin
            if (i_valid) begin
               take_res = 1'b1;
               state_d  = StNext;
            end
         end
         StNext:   state_d = last_n ? StCommit : StReq;
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n_q           <= '0;
         prev_spk_q    <= '0;
         cur_spk_q     <= '0;
         o_exc_current <= '0;
         o_inh_current <= '0;
         o_spike_vec   <= '0;
         o_winner      <= '0;
         o_winner_cnt  <= '0;
         o_rd_cnt      <= '0;
         o_err         <= 1'b0;
         for (int i = 0; i < N_NEURON; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         if (do_clear) begin
            prev_spk_q   <= '0;
            o_winner     <= '0;
            o_winner_cnt <= '0;
            o_err        <= 1'b0;
            for (int i = 0; i < N_NEURON; i++) begin
               cnt_q[i] <= '0;
            end
         end
         if (do_step) begin
            n_q       <= '0;
            cur_spk_q <= '0;
         end
         if (take_exc) begin
            o_exc_current <= i_exc_current;
            o_inh_current <= inh_cur;
         end
         if (take_res) begin
            // a mismatched engine index is flagged but the result still lands at n
            cur_spk_q[n_q] <= i_spike;
            cnt_q[n_q]     <= cnt_new;
            if (cnt_new > o_winner_cnt) begin
               o_winner     <= n_q;
               o_winner_cnt <= cnt_new;
            end
            if (i_neuron_idx != n_q) begin
               o_err <= 1'b1;
            end
         end
         if ((state_q == StNext) && !last_n) begin
            n_q <= n_q + IDX_W'(1);
         end
         if (state_q == StCommit) begin
            prev_spk_q  <= cur_spk_q;
            o_spike_vec <= cur_spk_q;
         end
         o_rd_cnt <= (i_rd_idx < IDX_W'(N_NEURON)) ? cnt_q[i_rd_idx] : '0;
      end
   end

endmodule
